// File: rtl/gtfraw_axil_cmd_master.sv
// gtfraw_axil_cmd_master: single-outstanding command to AXI4-Lite master bridge.
// Define AXIL_MASTER_TIMEOUT_EN to abort transactions after TIMEOUT_CYCLES busy cycles.
module gtfraw_axil_cmd_master #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_resp,
  output logic [31:0] m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [31:0] m_axi_araddr,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready
);
  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA} state_t;
  state_t state, state_n;
  logic [31:0] addr, addr_n, wdata, wdata_n, rdata_n;
  logic [1:0] resp_n;
  logic cmd_ready_n, awvalid_n, wvalid_n, bready_n, arvalid_n, rready_n, rsp_valid_n;
  logic accept;
  assign accept = cmd_valid && cmd_ready;
  assign m_axi_awaddr = addr;
  assign m_axi_araddr = addr;
  assign m_axi_wdata = wdata;
  assign m_axi_wstrb = 4'hF;
`ifdef AXIL_MASTER_TIMEOUT_EN
  logic [15:0] cnt, cnt_n;
  assign cnt_n = accept ? 16'd0 : (state != IDLE) ? cnt + 16'd1 : cnt;
  always_ff @(posedge aclk or posedge areset)
    if (areset) cnt <= '0;
    else cnt <= cnt_n;
`endif
  always_comb begin
    state_n = state;
    addr_n = addr;
    wdata_n = wdata;
    rdata_n = rsp_rdata;
    resp_n = rsp_resp;
    awvalid_n = m_axi_awvalid;
    wvalid_n = m_axi_wvalid;
    bready_n = m_axi_bready;
    arvalid_n = m_axi_arvalid;
    rready_n = m_axi_rready;
    rsp_valid_n = 1'b0;
    case (state)
      IDLE: if (accept) begin
        addr_n = cmd_addr;
        wdata_n = cmd_wdata;
        state_n = cmd_write ? WADDR : RADDR;
        awvalid_n = cmd_write;
        wvalid_n = cmd_write;
        arvalid_n = !cmd_write;
      end
      WADDR: begin
        awvalid_n = m_axi_awvalid && !m_axi_awready;
        wvalid_n = m_axi_wvalid && !m_axi_wready;
        if (!awvalid_n && !wvalid_n) begin
          state_n = WRESP;
          bready_n = 1'b1;
        end
      end
      WRESP: if (m_axi_bvalid) begin
        bready_n = 1'b0;
        rsp_valid_n = 1'b1;
        resp_n = m_axi_bresp;
        rdata_n = '0;
        state_n = IDLE;
      end
      RADDR: if (m_axi_arready) begin
        arvalid_n = 1'b0;
        rready_n = 1'b1;
        state_n = RDATA;
      end
      RDATA: if (m_axi_rvalid) begin
        rready_n = 1'b0;
        rsp_valid_n = 1'b1;
        resp_n = m_axi_rresp;
        rdata_n = m_axi_rdata;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
`ifdef AXIL_MASTER_TIMEOUT_EN
    // a handshake completing in the expiry cycle still wins over the abort
    if (state != IDLE && state_n != IDLE && cnt == 16'(TIMEOUT_CYCLES - 1)) begin
      awvalid_n = 1'b0;
      wvalid_n = 1'b0;
      bready_n = 1'b0;
      arvalid_n = 1'b0;
      rready_n = 1'b0;
      rsp_valid_n = 1'b1;
      resp_n = 2'b11;
      rdata_n = 32'hDEAD_DEAD;
      state_n = IDLE;
    end
`endif
    cmd_ready_n = state_n == IDLE;
  end
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      state <= IDLE;
      addr <= '0;
      wdata <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid <= 1'b0;
      m_axi_bready <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready <= 1'b0;
    end else begin
      state <= state_n;
      addr <= addr_n;
      wdata <= wdata_n;
      cmd_ready <= cmd_ready_n;
      rsp_valid <= rsp_valid_n;
      rsp_rdata <= rdata_n;
      rsp_resp <= resp_n;
      m_axi_awvalid <= awvalid_n;
      m_axi_wvalid <= wvalid_n;
      m_axi_bready <= bready_n;
      m_axi_arvalid <= arvalid_n;
      m_axi_rready <= rready_n;
    end
endmodule

// File: doc/gtfraw_axil_cmd_master.md
GTFRAW_AXIL_CMD_MASTER -- requirements
Module: gtfraw_axil_cmd_master
Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the number of busy cycles before a transaction is aborted (range 2..65535).
REQ-002 SHALL have aclk  in  1  clock for all logic; one clock; every output is registered to aclk.
REQ-003 SHALL have areset  in  1  reset, asynchronous assert, active-high.
REQ-004 SHALL have cmd_valid  in  1  command request.
REQ-005 SHALL have cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
REQ-006 SHALL have cmd_write  in  1  1=write, 0=read.
REQ-007 SHALL have cmd_addr  in  32  byte address, passed unchanged to the crossbar slave port.
REQ-008 SHALL have cmd_wdata  in  32  write data.
REQ-009 SHALL have rsp_valid  out  1  one-cycle completion pulse.
REQ-010 SHALL have rsp_rdata  out  32  read data (0 for writes).
REQ-011 SHALL have rsp_resp  out  2  AXI response, or 2'b11 on timeout.
REQ-012 SHALL have m_axi_awaddr  out  32  write address.
REQ-013 SHALL have m_axi_awvalid  out  1  write address valid.
REQ-014 SHALL have m_axi_awready  in  1  write address ready.
REQ-015 SHALL have m_axi_wdata  out  32  write data.
REQ-016 SHALL have m_axi_wstrb  out  4  constant 4'hF.
REQ-017 SHALL have m_axi_wvalid  out  1  write data valid.
REQ-018 SHALL have m_axi_wready  in  1  write data ready.
REQ-019 SHALL have m_axi_bresp  in  2  write response.
REQ-020 SHALL have m_axi_bvalid  in  1  write response valid.
REQ-021 SHALL have m_axi_bready  out  1  write response ready.
REQ-022 SHALL have m_axi_araddr  out  32  read address.
REQ-023 SHALL have m_axi_arvalid  out  1  read address valid.
REQ-024 SHALL have m_axi_arready  in  1  read address ready.
REQ-025 SHALL have m_axi_rdata  in  32  read data.
REQ-026 SHALL have m_axi_rresp  in  2  read response.
REQ-027 SHALL have m_axi_rvalid  in  1  read data valid.
REQ-028 SHALL have m_axi_rready  out  1  read data ready.
Function
REQ-029 SHALL implement FSM IDLE, WADDR, WRESP, RADDR, RDATA; cmd_ready=1 only in IDLE; commands arriving while busy are held off, not dropped.
REQ-030 SHALL on accept latch addr/wdata, then go to WADDR (write) or RADDR (read), with awvalid+wvalid or arvalid high in the next cycle.
REQ-031 SHALL in WADDR drop awvalid and wvalid independently, each in the cycle after its own ready; accepting both in the same cycle is legal; address/data stay stable while valid.
REQ-032 SHALL enter WRESP once both AW and W are accepted, holding bready=1 until bvalid; then assert rsp_valid and return to IDLE.
REQ-033 SHALL in RADDR hold arvalid until arready, then in RDATA hold rready=1 until rvalid; then assert rsp_valid with rsp_rdata=m_axi_rdata and rsp_resp=m_axi_rresp.
REQ-034 SHALL, for zero-wait slaves, give accept at T, valid at T+1, B/R handshake at T+2, rsp_valid at T+3, and cmd_ready high again at T+3.
REQ-035 SHALL register rsp_resp from bresp/rresp and set rsp_rdata=0 for writes; rsp_valid is high for exactly one cycle per accepted command.
Reset
REQ-036 SHALL on areset go to IDLE immediately, even mid-transaction; reset values: all valid/ready outputs 0, cmd_ready 0 during reset then 1, rsp_* 0, address/data 0, timeout counter 0.
Configuration
REQ-037 SHALL, with AXIL_MASTER_TIMEOUT_EN defined, use a 16-bit counter that clears on accept and increments every non-IDLE cycle; at TIMEOUT_CYCLES it drops all valid/ready outputs, pulses rsp_valid with rsp_resp=2'b11 and rsp_rdata=32'hDEAD_DEAD, and returns to IDLE; a late B/R is not acknowledged.
REQ-038 SHALL, without AXIL_MASTER_TIMEOUT_EN, omit the counter; the block waits indefinitely.
Verification
REQ-039 SHALL cover: write 0x0000_0010 data 0x1234_5678, slave ready immediately with bresp 0 -> AW/W at T+1, rsp_valid at T+3, rsp_resp 0.
REQ-040 SHALL cover: awready 3 cycles before wready -> awvalid drops first, wvalid holds until wready, exactly one B handshake.
REQ-041 SHALL cover: read 0x0001_0004, rvalid after 5 wait cycles with rdata 0xCAFE_F00D, rresp 2 -> rsp_rdata 0xCAFE_F00D, rsp_resp 2.
REQ-042 SHALL cover: with the macro defined and TIMEOUT_CYCLES=8, a slave that never responds -> rsp_resp 3, rdata 0xDEAD_DEAD, cmd_ready high again.
REQ-043 SHALL cover: areset asserted while in WRESP -> all valid/ready outputs low in the same cycle, no rsp_valid pulse, next command completes normally.
